dom_writeback: RTL

Output write-back unit for the CNN datapath. Receives per-cycle result writes from the compute array (the `dom_ready` / `dom_address` strobe produced by the address controller, plus the result word). Packs the results into one of two 8-word ping-pong banks. Drains each completed bank to the output memory over a valid/ready write port, so filling of the next layer's results overlaps draining of the previous one.

---
 rtl/cnn_pkg.sv | 8 +
 rtl/dom_bank.sv | 53 +++++
 rtl/dom_writeback.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN output write-back path.
package cnn_pkg;
  localparam int         DATA_W    = 16;
  localparam int         DOM_WORDS = 8;
  localparam logic [9:0] OUT_BASE  = 10'h200;

  typedef enum logic {WB_IDLE, WB_DRAIN} wb_state_t;
endpackage

// File: rtl/dom_bank.sv
// One 8-word result bank: sync write port, combinational read port,
// full flag, written mask for words 0..6 and the latched layer index.
module dom_bank #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_we,
  input  logic [2:0]        i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [1:0]        i_wlayer,
  input  logic              i_clr_full,
  input  logic [2:0]        i_raddr,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_full,
  output logic [6:0]        o_written,
  output logic [1:0]        o_layer
);
  import cnn_pkg::*;

  logic [DATA_W-1:0] r_mem [DOM_WORDS];
  logic              r_full;
  logic [6:0]        r_written;
  logic [1:0]        r_layer;

  // Data is not reset; stale words are only visible after being rewritten.
  always_ff @(posedge clock)
    if (i_we) r_mem[i_waddr] <= i_wdata;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_full    <= 1'b0;
      r_written <= '0;
      r_layer   <= '0;
    end else begin
      if (i_we) begin
        r_layer <= i_wlayer;
        if (i_waddr == 3'd7) begin
          r_full    <= 1'b1;
          r_written <= '0;
        end else begin
          r_written <= r_written | (7'h01 << i_waddr);
        end
      end
      if (i_clr_full) r_full <= 1'b0;
    end
  end

  assign o_rdata   = r_mem[i_raddr];
  assign o_full    = r_full;
  assign o_written = r_written;
  assign o_layer   = r_layer;
endmodule

// File: rtl/dom_writeback.sv
// Ping-pong result write-back: packs compute-array results into two banks
// and drains each completed bank to output memory over valid/ready.
module dom_writeback #(
  parameter int               DATA_W   = cnn_pkg::DATA_W,
  parameter int               ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] OUT_BASE = cnn_pkg::OUT_BASE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dom_ready,
  input  logic [2:0]        dom_address,
  input  logic [DATA_W-1:0] dom_data,
  input  logic [1:0]        layer,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_address,
  output logic [DATA_W-1:0] out_data,
  output logic              drained,
  output logic              busy,
  output logic              overflow,
  output logic              err_incomplete
);
  import cnn_pkg::*;

  logic [1:0]             w_full, w_we, w_clr;
  logic [1:0][6:0]        w_written;
  logic [1:0][1:0]        w_layer;
  logic [1:0][DATA_W-1:0] w_rdata;

  logic              r_fill_sel, r_drain_sel;
  wb_state_t         r_state;
  logic [2:0]        r_idx;
  logic              r_out_valid, r_drained, r_overflow, r_err;
  logic [ADDR_W-1:0] r_out_address;
  logic [DATA_W-1:0] r_out_data;

  logic              w_accept, w_complete, w_hs, w_last_hs;
  logic [2:0]        w_rd_idx;
  logic [ADDR_W-1:0] w_rd_addr;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    dom_bank #(.DATA_W(DATA_W)) u_bank (
      .clock      (clock),
      .reset      (reset),
      .i_we       (w_we[b]),
      .i_waddr    (dom_address),
      .i_wdata    (dom_data),
      .i_wlayer   (layer),
      .i_clr_full (w_clr[b]),
      .i_raddr    (w_rd_idx),
      .o_rdata    (w_rdata[b]),
      .o_full     (w_full[b]),
      .o_written  (w_written[b]),
      .o_layer    (w_layer[b])
    );
  end

  assign w_accept   = dom_ready & ~w_full[r_fill_sel];
  assign w_complete = w_accept & (dom_address == 3'd7);
  assign w_we       = {w_accept & r_fill_sel, w_accept & ~r_fill_sel};
  assign w_hs       = r_out_valid & out_ready;
  assign w_last_hs  = (r_state == WB_DRAIN) & w_hs & (r_idx == 3'd7);
  assign w_clr      = {w_last_hs & r_drain_sel, w_last_hs & ~r_drain_sel};

  // Read port looks one word ahead so the next word is ready at the handshake.
  // Each layer owns a 32-word slice of the output region.
  assign w_rd_idx  = (r_state == WB_DRAIN) ? r_idx + 3'd1 : 3'd0;
  assign w_rd_addr = OUT_BASE + ADDR_W'({w_layer[r_drain_sel], 2'b00, w_rd_idx});

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fill_sel <= 1'b0;
      r_overflow <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (dom_ready & w_full[r_fill_sel]) r_overflow <= 1'b1;
      if (w_complete) begin
        r_fill_sel <= ~r_fill_sel;
        if (w_written[r_fill_sel] != 7'h7F) r_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= WB_IDLE;
      r_idx         <= '0;
      r_drain_sel   <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_address <= '0;
      r_out_data    <= '0;
      r_drained     <= 1'b0;
    end else begin
      r_drained <= 1'b0;
      case (r_state)
        WB_IDLE:
          if (w_full[r_drain_sel]) begin
            r_idx         <= '0;
            r_out_data    <= w_rdata[r_drain_sel];
            r_out_address <= w_rd_addr;
            r_out_valid   <= 1'b1;
            r_state       <= WB_DRAIN;
          end
        WB_DRAIN:
          if (w_hs) begin
            if (r_idx != 3'd7) begin
              r_idx         <= r_idx + 3'd1;
              r_out_data    <= w_rdata[r_drain_sel];
              r_out_address <= w_rd_addr;
            end else begin
              r_out_valid <= 1'b0;
              r_drain_sel <= ~r_drain_sel;
              r_drained   <= 1'b1;
              r_state     <= WB_IDLE;
            end
          end
        default: r_state <= WB_IDLE;
      endcase
    end
  end

  assign out_valid      = r_out_valid;
  assign out_address    = r_out_address;
  assign out_data       = r_out_data;
  assign drained        = r_drained;
  assign busy           = |w_full | (r_state == WB_DRAIN);
  assign overflow       = r_overflow;
  assign err_incomplete = r_err;
endmodule
